alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Sequencer that computes a 16x16 unsigned multiply, producing a 32-bit result, by driving the shared 16-bit ALU through shift-add steps.
- Sits beside the simple CPU core. It requests the ALU from the core-side arbiter, owns its op/func/operand inputs while granted, and returns the product over a valid/ready response channel.
- Relies on the ALU convention that flags are registered at posedge and flags[0] is the carry used by shrc.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH. Only 16 is supported because the ALU is fixed-width.
- CNT_W, 4, bit-counter width, equal to log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  multiply request valid
- req_ready  out  1  block can accept a request
- req_a  in  16  multiplicand
- req_b  in  16  multiplier
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_prod  out  32  product {hi,lo}
- busy  out  1  operation in progress
- alu_req  out  1  request ownership of the ALU
- alu_gnt  in  1  arbiter grant; held high until alu_req drops
- alu_op  out  3  ALU major op; always 3'b000 while granted
- alu_func  out  4  ALU function select
- alu_s1  out  16  ALU operand 1
- alu_s2  out  16  ALU operand 2
- alu_result  in  16  combinational ALU result
- alu_flags  in  4  registered ALU flags {O,S,Z,C}

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_prod=0, busy=0, alu_req=0, alu_op=0, alu_func=0, alu_s1=0, alu_s2=0. Internal registers mcand, acc_hi, acc_lo and cnt are all 0; state is IDLE.
- Asserting rst_n low in any state aborts immediately to the reset values. No partial result is emitted.
- IDLE: req_ready=1. On req_valid&req_ready: mcand<=req_a, acc_lo<=req_b, acc_hi<=0, cnt<=0, go to WAIT_GNT.
- WAIT_GNT: alu_req=1, busy=1, req_ready=0. Stay while alu_gnt=0. On alu_gnt=1 go to ADD. alu_gnt is only sampled here, because the arbiter locks the grant.
- ADD: func=0001 (add), s1=acc_hi, s2 = acc_lo[0] ? mcand : 0. acc_hi<=alu_result. Next state is SHRH. The ALU captures the add carry into flags[0] at this edge.
- SHRH: func=1110 (shrc), s2=acc_hi. acc_hi<=alu_result, which is {carry, acc_hi[15:1]}. Flags[0] becomes the old acc_hi[0]. Next state is SHRL.
- SHRL: func=1110 (shrc), s2=acc_lo. acc_lo<=alu_result. cnt<=cnt+1.
  - If cnt==WIDTH-1, go to DONE.
  - Otherwise go to ADD.
- DONE: alu_req=0, rsp_valid=1, rsp_prod={acc_hi,acc_lo}, held stable while rsp_ready=0. On rsp_valid&rsp_ready go to IDLE with busy=0.
- A new request is accepted no earlier than the cycle after the response handshake.
- Latency from request accept to rsp_valid is 1 + G + 3*WIDTH cycles, where G is the number of grant-wait cycles. G=0 gives 49.
- alu_s1 and alu_s2 are 0 in states where the operand is unused.
- cnt wraps only through the DONE exit; there is no overflow path.
- ALU flags are never read directly by the block. The carry chain is carried inside the ALU flags register, so no other ALU user may intervene between ADD and SHRL.

Optional Feature:
- Macro: ALU_MUL_SEQ_SKIP_EN.
- When defined, the block enters ADD only if acc_lo[0]==1.
- When acc_lo[0]==0, SHRL and the grant path go to SHRH0 instead of ADD:
  - SHRH0 uses func=1010 (shr) on acc_hi, which shifts in 0 and sets C=acc_hi[0].
  - SHRH0 then goes to SHRL.
- Each zero multiplier bit costs 2 cycles and each one bit costs 3, so latency = 1 + G + 2*WIDTH + popcount(req_b).
- When undefined, every bit takes 3 cycles and the latency is fixed at 49 (G=0).
- Products are identical either way.

Test Plan:
- Reset mid-operation: assert rst_n=0 in the cycle after ADD. All outputs return to reset values and alu_req=0. A subsequent 3*5 request yields rsp_prod=0x0000000F.
- Worst-case carry: req_a=0xFFFF, req_b=0xFFFF, alu_gnt tied to 1. rsp_prod=0xFFFE0001 and rsp_valid rises exactly 49 cycles after accept (feature off).
- Zero operands: 0x1234*0x0000 gives 0x00000000, and 0x0000*0xBEEF gives 0x00000000. With ALU_MUL_SEQ_SKIP_EN, 0x1234*0x0000 completes in 33 cycles.
- Grant stall: alu_gnt held low for 7 cycles. alu_op/func stay 0 and busy=1. Result 0x00FF*0x0101 = 0x0000FFFF at latency 56.
- Response backpressure: rsp_ready=0 for 10 cycles after rsp_valid. rsp_prod stays stable, req_ready=0, and alu_req=0. The next request is accepted only after the handshake.
- Back-to-back: 0x8000*0x0002 = 0x00010000, then 0x7FFF*0x7FFF = 0x3FFF0001. Both are correct, with no flag leakage between operations.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 unsigned multiplier that borrows the shared ALU one bit per pass.
// Optional macro ALU_MUL_SEQ_SKIP_EN skips the add pass for zero multiplier bits.
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_prod,
    output logic               busy,
    output logic               alu_req,
    input  logic               alu_gnt,
    output logic [2:0]         alu_op,
    output logic [3:0]         alu_func,
    output logic [WIDTH-1:0]   alu_s1,
    output logic [WIDTH-1:0]   alu_s2,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [3:0]         alu_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GNT,
        S_ADD,
        S_SHRH,
        S_SHRL,
        S_DONE,
        S_SHRH0
    } state_t;

    localparam logic [3:0]       FUNC_ADD  = 4'b0001;
    localparam logic [3:0]       FUNC_SHRC = 4'b1110;
    localparam logic [3:0]       FUNC_SHR  = 4'b1010;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

`ifdef ALU_MUL_SEQ_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic               first_add;
    logic               next_add;

    // The carry chain lives in the ALU flags register; the block never reads it.
    logic unused_flags;
    assign unused_flags = ^alu_flags;

    assign alu_op = 3'b000;

    // With skipping, a bit pass starts with ADD only when the multiplier bit is 1;
    // after SHRL the next bit to examine is the current acc_lo[1].
    assign first_add = !SKIP_EN || acc_lo[0];
    assign next_add  = !SKIP_EN || acc_lo[1];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, matching the ALU's own registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every register here is reset, so an abort leaves no stale partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        mcand  <= req_a;
                        acc_lo <= req_b;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                S_ADD, S_SHRH, S_SHRH0: begin
                    acc_hi <= alu_result;
                end
                S_SHRL: begin
                    acc_lo <= alu_result;
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can infer a latch.
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_prod  = '0;
        busy      = 1'b1;
        alu_req   = 1'b0;
        alu_func  = 4'b0000;
        alu_s1    = '0;
        alu_s2    = '0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_n = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                alu_req = 1'b1;
                if (alu_gnt) begin
                    state_n = first_add ? S_ADD : S_SHRH0;
                end
            end
            S_ADD: begin
                alu_req  = 1'b1;
                alu_func = FUNC_ADD;
                alu_s1   = acc_hi;
                alu_s2   = acc_lo[0] ? mcand : '0;
                state_n  = S_SHRH;
            end
            S_SHRH: begin
                alu_req  = 1'b1;
                alu_func = FUNC_SHRC;
                alu_s2   = acc_hi;
                state_n  = S_SHRL;
            end
            S_SHRH0: begin
                alu_req  = 1'b1;
                alu_func = FUNC_SHR;
                alu_s2   = acc_hi;
                state_n  = S_SHRL;
            end
            S_SHRL: begin
                alu_req  = 1'b1;
                alu_func = FUNC_SHRC;
                alu_s2   = acc_lo;
                if (cnt == CNT_LAST) begin
                    state_n = S_DONE;
                end else begin
                    state_n = next_add ? S_ADD : S_SHRH0;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_prod  = {acc_hi, acc_lo};
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
